// File: rtl/free_list.sv
// Circular free list of physical register tags feeding the rename map table.
// Hands out up to RENAME_PORTS tags per cycle, recycles tags released at commit, and rolls back on flush.
module free_list #(
    parameter int ARCH_REGS    = 32,
    parameter int PHYS_REGS    = 48,
    parameter int RENAME_PORTS = 2,
    parameter int COMMIT_PORTS = 2,
    localparam int PW          = $clog2(PHYS_REGS),
    localparam int DEPTH       = PHYS_REGS - ARCH_REGS,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RENAME_PORTS-1:0]      alloc_en,
    output logic [RENAME_PORTS*PW-1:0]   alloc_phys,
    output logic                         alloc_ready,
    input  logic [COMMIT_PORTS-1:0]      commit_en,
    input  logic [COMMIT_PORTS*PW-1:0]   commit_old_phys,
    input  logic                         flush_pipeline,
    output logic [CW-1:0]                free_count,
    output logic                         overflow_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a rename slot j takes alloc_phys[j] in the cycle it raises alloc_en[j]
    // while alloc_ready is high; when alloc_ready is low the requests are dropped and the
    // rename stage must hold its instructions and retry.

    logic [PW-1:0] fl [DEPTH];
    logic [IW-1:0] spec_head;
    logic [IW-1:0] commit_head;
    logic [IW-1:0] tail;
    logic [CW-1:0] spec_count;
    logic [CW-1:0] commit_count;

    logic [CW-1:0] n_alloc;
    logic [CW-1:0] n_pop;
    logic [CW-1:0] n_push;
    logic [CW-1:0] eff_push;
    logic [CW-1:0] n_commit;
    logic [COMMIT_PORTS-1:0] push_we;
    logic [IW-1:0] push_idx [COMMIT_PORTS];
    logic          push_ovf;
    logic          push_do;
    logic [CW-1:0] spec_count_nxt;
    logic [CW-1:0] commit_count_nxt;

    // Index advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] idx, input logic [CW-1:0] n);
        int s;
        s = int'(idx) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return IW'(s);
    endfunction

    // Compacted allocation: each enabled slot takes the next entry after those claimed by lower slots.
    always_comb begin
        alloc_phys = '0;
        n_alloc    = '0;
        for (int j = 0; j < RENAME_PORTS; j++) begin
            alloc_phys[j*PW +: PW] = fl[wrap_add(spec_head, n_alloc)];
            n_alloc = n_alloc + CW'(alloc_en[j]);
        end
    end

    // Releases of tag 0 are dropped but still retire their allocation from the committed view.
    always_comb begin
        n_push   = '0;
        n_commit = '0;
        push_we  = '0;
        for (int j = 0; j < COMMIT_PORTS; j++) begin
            push_idx[j] = wrap_add(tail, n_push);
            push_we[j]  = commit_en[j] && (commit_old_phys[j*PW +: PW] != '0);
            n_push      = n_push + CW'(push_we[j]);
            n_commit    = n_commit + CW'(commit_en[j]);
        end
    end

    always_comb begin
        push_ovf = (int'(spec_count) + int'(n_push) > DEPTH) ||
                   (int'(commit_count) + int'(n_push) - int'(n_commit) > DEPTH);
        push_do  = !flush_pipeline && !push_ovf;
        eff_push = push_do ? n_push : '0;
        n_pop    = (alloc_ready && !flush_pipeline) ? n_alloc : '0;
        if (flush_pipeline) begin
            spec_count_nxt   = commit_count;
            commit_count_nxt = commit_count;
        end else begin
            spec_count_nxt   = spec_count + eff_push - n_pop;
            commit_count_nxt = commit_count + eff_push - n_commit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl[i] <= PW'(ARCH_REGS + i);
            end
            spec_head    <= '0;
            commit_head  <= '0;
            tail         <= '0;
            spec_count   <= CW'(DEPTH);
            commit_count <= CW'(DEPTH);
            alloc_ready  <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            spec_count   <= spec_count_nxt;
            commit_count <= commit_count_nxt;
            alloc_ready  <= (spec_count_nxt >= CW'(RENAME_PORTS));
            if (flush_pipeline) begin
                spec_head <= commit_head;
            end else begin
                spec_head   <= wrap_add(spec_head, n_pop);
                commit_head <= wrap_add(commit_head, n_commit);
                if (push_ovf) begin
                    overflow_err <= 1'b1;
                end
                if (push_do) begin
                    tail <= wrap_add(tail, n_push);
                    for (int j = 0; j < COMMIT_PORTS; j++) begin
                        if (push_we[j]) begin
                            fl[push_idx[j]] <= commit_old_phys[j*PW +: PW];
                        end
                    end
                end
            end
        end
    end

    assign free_count = spec_count;

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus random traffic, checked against a queue-based model.
module tb_free_list;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  alloc_en = '0;
    logic [11:0] alloc_phys;
    logic        alloc_ready;
    logic [1:0]  commit_en = '0;
    logic [11:0] commit_old_phys = '0;
    logic        flush_pipeline = 1'b0;
    logic [4:0]  free_count;
    logic        overflow_err;

    free_list dut (
        .clk(clk), .reset(reset), .alloc_en(alloc_en), .alloc_phys(alloc_phys),
        .alloc_ready(alloc_ready), .commit_en(commit_en), .commit_old_phys(commit_old_phys),
        .flush_pipeline(flush_pipeline), .free_count(free_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: spec_q holds allocatable tags in order, infl_q holds tags handed out
    // but not yet committed (oldest first).
    int spec_q[$];
    int infl_q[$];
    bit m_ovf;

    logic [5:0] exp_q[$];
    logic [6:0] st_q[$];
    bit run = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        spec_q.delete();
        infl_q.delete();
        for (int i = 0; i < DEPTH; i++) spec_q.push_back(32 + i);
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        run = 1'b0;
        alloc_en = '0; commit_en = '0; commit_old_phys = '0; flush_pipeline = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("reset_free_count", 32'(free_count), DEPTH);
        check("reset_alloc_ready", 32'(alloc_ready), 1);
        check("reset_overflow", 32'(overflow_err), 0);
        check("reset_phys_known", 32'($isunknown(alloc_phys)), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One cycle of stimulus; the expected status and tags are queued for the monitor.
    task automatic cyc(input logic [1:0] ae, input logic [1:0] ce,
                       input logic [5:0] o0, input logic [5:0] o1, input logic fl);
        int k;
        int c;
        int pushq[$];
        bit rdy;
        @(posedge clk); #1;
        alloc_en = ae;
        commit_en = ce;
        commit_old_phys = {o1, o0};
        flush_pipeline = fl;
        rdy = spec_q.size() >= 2;
        st_q.push_back({m_ovf, rdy, 5'(spec_q.size())});
        k = 0;
        if (rdy && !fl) begin
            for (int j = 0; j < 2; j++) begin
                if (ae[j]) begin
                    exp_q.push_back(6'(spec_q[k]));
                    k++;
                end
            end
        end
        if (fl) begin
            spec_q = {infl_q, spec_q};
            infl_q.delete();
        end else begin
            c = int'(ce[0]) + int'(ce[1]);
            if (ce[0] && o0 != 0) pushq.push_back(int'(o0));
            if (ce[1] && o1 != 0) pushq.push_back(int'(o1));
            if (spec_q.size() + pushq.size() > DEPTH ||
                infl_q.size() + spec_q.size() - c + pushq.size() > DEPTH) begin
                m_ovf = 1'b1;
                pushq.delete();
            end
            repeat (c) if (infl_q.size() > 0) void'(infl_q.pop_front());
            repeat (k) infl_q.push_back(spec_q.pop_front());
            foreach (pushq[i]) spec_q.push_back(pushq[i]);
        end
        run = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [6:0] es;
        logic [5:0] et;
        if (run) begin
            if (st_q.size() == 0) check("status_queue_empty", 1, 0);
            else begin
                es = st_q.pop_front();
                check("status", 32'({overflow_err, alloc_ready, free_count}), 32'(es));
            end
            for (int j = 0; j < 2; j++) begin
                if (alloc_ready && !flush_pipeline && alloc_en[j]) begin
                    if (exp_q.size() == 0) check("alloc_unexpected", 32'(j), 99);
                    else begin
                        et = exp_q.pop_front();
                        check(j == 0 ? "alloc_slot0" : "alloc_slot1",
                              32'(alloc_phys[j*6 +: 6]), 32'(et));
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] ae;
        logic [1:0] ce;
        int ninf;
        int c;
        model_reset();

        // Drain, stall, refill with released tags.
        do_reset();
        repeat (9) cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b00, 2'b11, 6'd5, 6'd7, 1'b0);
        cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);

        // Flush after one commit: freed tag lands after the original entries.
        do_reset();
        cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b00, 2'b01, 6'd3, 6'd0, 1'b0);
        cyc(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
        repeat (9) cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);

        // Compaction onto slot 1.
        do_reset();
        cyc(2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);

        // Release into a full list.
        do_reset();
        cyc(2'b00, 2'b01, 6'd9, 6'd0, 1'b0);
        cyc(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);

        // Flush with allocate and commit requests in the same cycle.
        do_reset();
        cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b11, 2'b11, 6'd10, 6'd11, 1'b1);
        cyc(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);

        // Random legal traffic: commits never exceed outstanding allocations.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ae = 2'($urandom_range(0, 3));
            ninf = infl_q.size();
            c = $urandom_range(0, (ninf < 2) ? ninf : 2);
            ce = (c == 2) ? 2'b11 : (c == 1) ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'b00;
            cyc(ae, ce,
                ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 47)),
                ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 47)),
                ($urandom_range(0, 19) == 0));
        end

        @(posedge clk); #1;
        run = 1'b0;
        alloc_en = '0; commit_en = '0; flush_pipeline = 1'b0;
        @(negedge clk);
        check("tag_queue_drained", 32'(exp_q.size()), 0);
        check("status_queue_drained", 32'(st_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
